// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter and sequencer for the
// shared 16-bit memory port. Requester 0 is instruction fetch, requester 1 is
// data load/store. Every output is registered: each *_d value is computed
// from the state being entered, so the flop shows it during that state.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        sel,
    output logic        busy
);

    // Counter holds at most MEM_LAT-1; keep at least one bit for MEM_LAT=1.
    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic          sel_q, sel_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic          busy_q, busy_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [15:0]   mem_wdata_q, mem_wdata_d;
    logic [15:0]   rdata_q, rdata_d;

    logic          any_req;
    logic          winner;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        any_req = req0 | req1;
        winner  = (req0 & req1) ? ~last_q : req1;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        we_d        = we_q;
        sel_d       = sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d       = winner;
                    last_d      = winner;
                    mem_addr_d  = winner ? addr1  : addr0;
                    mem_wdata_d = winner ? wdata1 : wdata0;
                    we_d        = winner ? we1    : we0;
                    gnt0_d      = ~winner;
                    gnt1_d      = winner;
                    // The access strobe is shown during ACCESS, together with gnt.
                    mem_en_d    = 1'b1;
                    mem_we_d    = winner ? we1 : we0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = CW'(MEM_LAT - 1);
                if (MEM_LAT == 1) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
                done0_d = ~sel_q;
                done1_d = sel_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            sel_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign sel       = sel_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance 0 built with MEM_LAT=2,
// instance 1 with MEM_LAT=1. The driver pushes expected grant/done events;
// a negedge monitor pops and compares them as the DUTs present them.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    logic mon_on;

    logic        req0_s [2];
    logic        req1_s [2];
    logic [15:0] addr0_s [2];
    logic [15:0] addr1_s [2];
    logic [15:0] wdata0_s [2];
    logic [15:0] wdata1_s [2];
    logic        we0_s [2];
    logic        we1_s [2];
    logic        gnt0_s [2];
    logic        gnt1_s [2];
    logic        done0_s [2];
    logic        done1_s [2];
    logic [15:0] rdata_s [2];
    logic        mem_en_s [2];
    logic        mem_we_s [2];
    logic [15:0] mem_addr_s [2];
    logic [15:0] mem_wdata_s [2];
    logic [15:0] mem_rdata_s [2];
    logic        sel_s [2];
    logic        busy_s [2];

    typedef struct {
        int          inst;
        int          cyc;
        logic        id;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic [15:0] rdata;
    } exp_t;

    exp_t gq[$];
    exp_t dq[$];

    mem_port_arbiter #(.MEM_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst),
        .req0(req0_s[0]), .req1(req1_s[0]),
        .addr0(addr0_s[0]), .addr1(addr1_s[0]),
        .wdata0(wdata0_s[0]), .wdata1(wdata1_s[0]),
        .we0(we0_s[0]), .we1(we1_s[0]),
        .gnt0(gnt0_s[0]), .gnt1(gnt1_s[0]),
        .done0(done0_s[0]), .done1(done1_s[0]),
        .rdata(rdata_s[0]),
        .mem_en(mem_en_s[0]), .mem_we(mem_we_s[0]),
        .mem_addr(mem_addr_s[0]), .mem_wdata(mem_wdata_s[0]),
        .mem_rdata(mem_rdata_s[0]),
        .sel(sel_s[0]), .busy(busy_s[0])
    );

    mem_port_arbiter #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req0(req0_s[1]), .req1(req1_s[1]),
        .addr0(addr0_s[1]), .addr1(addr1_s[1]),
        .wdata0(wdata0_s[1]), .wdata1(wdata1_s[1]),
        .we0(we0_s[1]), .we1(we1_s[1]),
        .gnt0(gnt0_s[1]), .gnt1(gnt1_s[1]),
        .done0(done0_s[1]), .done1(done1_s[1]),
        .rdata(rdata_s[1]),
        .mem_en(mem_en_s[1]), .mem_we(mem_we_s[1]),
        .mem_addr(mem_addr_s[1]), .mem_wdata(mem_wdata_s[1]),
        .mem_rdata(mem_rdata_s[1]),
        .sel(sel_s[1]), .busy(busy_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model contents: two fixed words, everything else addr ^ 0xA5A5.
    function automatic logic [15:0] mem_val(input logic [15:0] a);
        case (a)
            16'h0040: return 16'hBEEF;
            16'h00FF: return 16'h5A5A;
            default:  return a ^ 16'hA5A5;
        endcase
    endfunction

    // Read data is valid only MEM_LAT cycles after the mem_en cycle; 0xDEAD otherwise.
    logic [1:0]  en2 = '0;
    logic [15:0] a2a = '0;
    logic [15:0] a2b = '0;
    logic        en1 = 1'b0;
    logic [15:0] a1 = '0;
    always @(posedge clk) begin
        en2 <= {en2[0], mem_en_s[0]};
        a2a <= mem_addr_s[0];
        a2b <= a2a;
        en1 <= mem_en_s[1];
        a1  <= mem_addr_s[1];
    end
    assign mem_rdata_s[0] = en2[1] ? mem_val(a2b) : 16'hDEAD;
    assign mem_rdata_s[1] = en1 ? mem_val(a1) : 16'hDEAD;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [55:0] outs(input int k);
        return {gnt0_s[k], gnt1_s[k], done0_s[k], done1_s[k], mem_en_s[k], mem_we_s[k],
                sel_s[k], busy_s[k], mem_addr_s[k], mem_wdata_s[k], rdata_s[k]};
    endfunction

    task automatic exp_gnt(input int inst, input int c, input logic id, input logic [15:0] a,
                           input logic [15:0] w, input logic we);
        exp_t e;
        e.inst = inst; e.cyc = c; e.id = id; e.addr = a; e.wdata = w; e.we = we; e.rdata = '0;
        gq.push_back(e);
    endtask

    task automatic exp_done(input int inst, input int c, input logic id, input logic [15:0] rd);
        exp_t e;
        e.inst = inst; e.cyc = c; e.id = id; e.addr = '0; e.wdata = '0; e.we = 1'b0; e.rdata = rd;
        dq.push_back(e);
    endtask

    task automatic observe(input int k);
        exp_t e;
        chk("gnt_exclusive", 64'(gnt0_s[k] & gnt1_s[k]), 64'(0));
        chk("done_exclusive", 64'(done0_s[k] & done1_s[k]), 64'(0));
        chk("mem_en_with_gnt", 64'(mem_en_s[k]), 64'(gnt0_s[k] | gnt1_s[k]));
        if (mem_we_s[k]) chk("mem_we_with_en", 64'(mem_en_s[k]), 64'(1));
        if (gnt0_s[k] | gnt1_s[k]) begin
            if (gq.size() == 0 || gq[0].inst != k) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_gnt inst %0d @cyc %0d: got gnt0=%0d gnt1=%0d want none",
                         k, cyc, gnt0_s[k], gnt1_s[k]);
            end else begin
                e = gq.pop_front();
                chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
                chk("gnt_id", 64'(gnt1_s[k]), 64'(e.id));
                chk("gnt_sel", 64'(sel_s[k]), 64'(e.id));
                chk("gnt_mem_we", 64'(mem_we_s[k]), 64'(e.we));
                chk("gnt_mem_addr", 64'(mem_addr_s[k]), 64'(e.addr));
                chk("gnt_mem_wdata", 64'(mem_wdata_s[k]), 64'(e.wdata));
                chk("gnt_busy", 64'(busy_s[k]), 64'(1));
            end
        end
        if (done0_s[k] | done1_s[k]) begin
            if (dq.size() == 0 || dq[0].inst != k) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_done inst %0d @cyc %0d: got done0=%0d done1=%0d want none",
                         k, cyc, done0_s[k], done1_s[k]);
            end else begin
                e = dq.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("done_id", 64'(done1_s[k]), 64'(e.id));
                chk("done_rdata", 64'(rdata_s[k]), 64'(e.rdata));
                chk("done_busy", 64'(busy_s[k]), 64'(0));
            end
        end
    endtask

    // Monitor: flag expectations whose cycle has passed, then check both instances.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                while (gq.size() > 0 && gq[0].cyc < cyc) begin
                    n_cmp++; n_fail++;
                    $display("FAIL missed_gnt inst %0d: got none want gnt%0d @cyc %0d",
                             gq[0].inst, gq[0].id, gq[0].cyc);
                    void'(gq.pop_front());
                end
                while (dq.size() > 0 && dq[0].cyc < cyc) begin
                    n_cmp++; n_fail++;
                    $display("FAIL missed_done inst %0d: got none want done%0d @cyc %0d",
                             dq[0].inst, dq[0].id, dq[0].cyc);
                    void'(dq.pop_front());
                end
                observe(0);
                observe(1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            req0_s[k] = 1'b0; req1_s[k] = 1'b0;
            addr0_s[k] = '0; addr1_s[k] = '0;
            wdata0_s[k] = '0; wdata1_s[k] = '0;
            we0_s[k] = 1'b0; we1_s[k] = 1'b0;
        end
    endtask

    // One uncontested transaction: grant at T+1, done at T+2+MEM_LAT.
    task automatic single(input int k, input logic id, input logic [15:0] a,
                          input logic [15:0] w, input logic we, input logic [15:0] rd);
        int t;
        int lat;
        t = cyc;
        lat = (k == 0) ? 2 : 1;
        if (id) begin
            addr1_s[k] = a; wdata1_s[k] = w; we1_s[k] = we; req1_s[k] = 1'b1;
        end else begin
            addr0_s[k] = a; wdata0_s[k] = w; we0_s[k] = we; req0_s[k] = 1'b1;
        end
        exp_gnt(k, t + 1, id, a, w, we);
        exp_done(k, t + 2 + lat, id, rd);
        tick(1);
        req0_s[k] = 1'b0;
        req1_s[k] = 1'b0;
        tick(lat + 2);
    endtask

    initial begin
        int t;
        n_cmp = 0;
        n_fail = 0;
        mon_on = 1'b0;
        clear_inputs();
        rst = 1'b1;
        tick(1);

        // Reset held with random inputs: every output must read 0.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) begin
                req0_s[k] = 1'($urandom); req1_s[k] = 1'($urandom);
                addr0_s[k] = 16'($urandom); addr1_s[k] = 16'($urandom);
                wdata0_s[k] = 16'($urandom); wdata1_s[k] = 16'($urandom);
                we0_s[k] = 1'($urandom); we1_s[k] = 1'($urandom);
            end
            tick(1);
            chk("reset_outputs_lat2", 64'(outs(0)), 64'(0));
            chk("reset_outputs_lat1", 64'(outs(1)), 64'(0));
        end
        clear_inputs();
        rst = 1'b0;
        mon_on = 1'b1;
        tick(1);

        // First tie after reset goes to requester 0, then requester 1.
        t = cyc;
        addr0_s[0] = 16'h0010; wdata0_s[0] = 16'h0101; we0_s[0] = 1'b0; req0_s[0] = 1'b1;
        addr1_s[0] = 16'h0020; wdata1_s[0] = 16'h0202; we1_s[0] = 1'b0; req1_s[0] = 1'b1;
        exp_gnt(0, t + 1, 1'b0, 16'h0010, 16'h0101, 1'b0);
        exp_done(0, t + 4, 1'b0, 16'hA5B5);
        exp_gnt(0, t + 5, 1'b1, 16'h0020, 16'h0202, 1'b0);
        exp_done(0, t + 8, 1'b1, 16'hA585);
        tick(1);
        req0_s[0] = 1'b0;
        tick(4);
        req1_s[0] = 1'b0;
        tick(4);

        // Single read of 0x0040 returning 0xBEEF.
        single(0, 1'b0, 16'h0040, 16'h0BAD, 1'b0, 16'hBEEF);
        // Write from requester 1; rdata keeps 0xBEEF.
        single(0, 1'b1, 16'h0100, 16'h1234, 1'b1, 16'hBEEF);

        // Continuous contention: 0,1,0,1. Grant-to-grant spacing is MEM_LAT+2
        // (ACCESS, MEM_LAT-1 waits, RESP, then the IDLE cycle carrying done).
        t = cyc;
        addr0_s[0] = 16'h0200; wdata0_s[0] = 16'h2222; we0_s[0] = 1'b0; req0_s[0] = 1'b1;
        addr1_s[0] = 16'h0300; wdata1_s[0] = 16'hCAFE; we1_s[0] = 1'b1; req1_s[0] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            exp_gnt(0, t + 1 + 8 * r, 1'b0, 16'h0200, 16'h2222, 1'b0);
            exp_done(0, t + 4 + 8 * r, 1'b0, 16'hA7A5);
            exp_gnt(0, t + 5 + 8 * r, 1'b1, 16'h0300, 16'hCAFE, 1'b1);
            exp_done(0, t + 8 + 8 * r, 1'b1, 16'hA7A5);
        end
        tick(10);
        req0_s[0] = 1'b0;
        tick(4);
        req1_s[0] = 1'b0;
        tick(4);

        // Reset during the WAIT cycle of a requester-1 read: no done, outputs 0.
        t = cyc;
        addr1_s[0] = 16'h0400; wdata1_s[0] = 16'h4444; we1_s[0] = 1'b0; req1_s[0] = 1'b1;
        exp_gnt(0, t + 1, 1'b1, 16'h0400, 16'h4444, 1'b0);
        tick(1);
        req1_s[0] = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("midop_reset_lat2", 64'(outs(0)), 64'(0));
        chk("midop_reset_lat1", 64'(outs(1)), 64'(0));
        rst = 1'b0;
        tick(2);
        // Re-issued request completes with the normal latency.
        single(0, 1'b1, 16'h0400, 16'h4444, 1'b0, 16'hA1A5);

        // MEM_LAT=1 build: done two cycles after the grant, no WAIT.
        single(1, 1'b0, 16'h00FF, 16'h0F0F, 1'b0, 16'h5A5A);

        tick(3);
        chk("gnt_queue_drained", 64'(gq.size()), 64'(0));
        chk("done_queue_drained", 64'(dq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want finish before 200000");
        $fatal(1);
    end

endmodule
